// File: rtl/qpsk_map_mimo_if.sv
// Byte-in / dual-antenna-symbol-out handshake bundle for the QPSK MIMO mapper.
interface qpsk_map_mimo_if #(
   parameter int unsigned DATA_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [7:0]               in_byte;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] X1_re;
   logic signed [DATA_W-1:0] X1_im;
   logic signed [DATA_W-1:0] X2_re;
   logic signed [DATA_W-1:0] X2_im;
   logic                     out_last;

   // Upstream byte source / downstream symbol sink side.
   modport master (
      output in_valid, in_byte, out_ready,
      input  in_ready, out_valid, X1_re, X1_im, X2_re, X2_im, out_last
   );

   // Mapper side.
   modport slave (
      input  in_valid, in_byte, out_ready,
      output in_ready, out_valid, X1_re, X1_im, X2_re, X2_im, out_last
   );
endinterface

// File: rtl/qpsk_map_mimo.sv
// QPSK mapper for 2x MIMO: each byte yields two symbol vectors (high nibble
// first), each nibble bit selecting +AMP or -AMP on one antenna I/Q component.
module qpsk_map_mimo #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned AMP        = 23170,
   parameter int unsigned FRAME_SYMS = 64
) (
   input logic            clk,
   input logic            rst_n,
   qpsk_map_mimo_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(FRAME_SYMS);
   localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(FRAME_SYMS - 1);
   localparam logic signed [DATA_W-1:0] POS      = DATA_W'(AMP);
   localparam logic signed [DATA_W-1:0] NEG      = -POS;

   typedef enum logic [1:0] {IDLE, HI, LO} state_t;

   state_t                   state_q, state_d;
   logic [7:0]               buf_q, buf_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     valid_q, valid_d;
   logic                     last_q, last_d;
   logic signed [DATA_W-1:0] x1r_q, x1r_d, x1i_q, x1i_d;
   logic signed [DATA_W-1:0] x2r_q, x2r_d, x2i_q, x2i_d;
   logic                     slot_free;
   logic                     in_ready;
   logic                     in_xfer;
   logic                     load;
   logic [3:0]               nib;

   // Bit 0 -> +AMP, bit 1 -> -AMP, so a sign slicer recovers the bit.
   function automatic logic signed [DATA_W-1:0] map_bit(input logic b);
      return b ? NEG : POS;
   endfunction

   assign slot_free = !valid_q || bus.out_ready;
   assign in_xfer   = bus.in_valid && in_ready;

   // Accept a byte only when the buffer is empty or its last nibble is leaving.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         LO:      in_ready = slot_free;
         default: in_ready = 1'b0;
      endcase
   end

   // Next-state, buffer and output-register load logic.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      load    = 1'b0;
      nib     = buf_q[7:4];
      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               buf_d   = bus.in_byte;
               state_d = HI;
            end
         end
         HI: begin
            if (slot_free) begin
               load    = 1'b1;
               state_d = LO;
            end
         end
         LO: begin
            if (slot_free) begin
               load = 1'b1;
               nib  = buf_q[3:0];
               if (in_xfer) begin
                  buf_d   = bus.in_byte;
                  state_d = HI;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      valid_d = load || (valid_q && !bus.out_ready);
      cnt_d   = cnt_q;
      last_d  = last_q;
      x1r_d   = x1r_q;
      x1i_d   = x1i_q;
      x2r_d   = x2r_q;
      x2i_d   = x2i_q;
      if (load) begin
         cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
         last_d = (cnt_q == LAST_CNT);
         x1r_d  = map_bit(nib[3]);
         x1i_d  = map_bit(nib[2]);
         x2r_d  = map_bit(nib[1]);
         x2i_d  = map_bit(nib[0]);
      end
   end

   // State and output registers; reset discards any buffered byte and symbol.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         x1r_q   <= '0;
         x1i_q   <= '0;
         x2r_q   <= '0;
         x2i_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         x1r_q   <= x1r_d;
         x1i_q   <= x1i_d;
         x2r_q   <= x2r_d;
         x2i_q   <= x2i_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_last  = last_q;
   assign bus.X1_re     = x1r_q;
   assign bus.X1_im     = x1i_q;
   assign bus.X2_re     = x2r_q;
   assign bus.X2_im     = x2i_q;
endmodule

// File: tb/tb_qpsk_map_mimo.sv
// Self-checking bench for qpsk_map_mimo: directed cases plus a randomized
// stream checked by a sign-slicing demapper scoreboard.
module tb_qpsk_map_mimo;
   localparam int unsigned DATA_W = 16;
   localparam int          AMP    = 23170;
   localparam int          FRAME  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   qpsk_map_mimo_if #(.DATA_W(DATA_W)) bus ();

   qpsk_map_mimo #(
      .DATA_W    (DATA_W),
      .AMP       (AMP),
      .FRAME_SYMS(FRAME)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Count one comparison and report it if it does not hold.
   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   // Expected component value for bit k of a nibble.
   function automatic int sym(input logic [3:0] n, input int k);
      return n[k] ? -AMP : AMP;
   endfunction

   task automatic chk_sym(input string tag, input logic [3:0] n);
      chk({tag, ".x1r"}, 32'(bus.X1_re), sym(n, 3));
      chk({tag, ".x1i"}, 32'(bus.X1_im), sym(n, 2));
      chk({tag, ".x2r"}, 32'(bus.X2_re), sym(n, 1));
      chk({tag, ".x2i"}, 32'(bus.X2_im), sym(n, 0));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid), 0);
      chk({tag, ".last"}, 32'(bus.out_last), 0);
      chk({tag, ".inready"}, 32'(bus.in_ready), 1);
      chk({tag, ".x1r"}, 32'(bus.X1_re), 0);
      chk({tag, ".x1i"}, 32'(bus.X1_im), 0);
      chk({tag, ".x2r"}, 32'(bus.X2_re), 0);
      chk({tag, ".x2i"}, 32'(bus.X2_im), 0);
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   // Reference model: queue of nibbles owed downstream, plus transfer index
   // within the frame since reset.
   logic [3:0] exp_q[$];
   int         xfer_idx;
   logic [3:0] seen;
   logic       mag_ok;

   function automatic logic is_amp(input logic signed [DATA_W-1:0] v);
      return (32'(v) == AMP) || (32'(v) == -AMP);
   endfunction

   // Scoreboard: every displayed symbol must demap to the oldest owed nibble.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         xfer_idx = 0;
      end else begin
         if (bus.out_valid) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               seen   = {bus.X1_re < 0, bus.X1_im < 0, bus.X2_re < 0, bus.X2_im < 0};
               mag_ok = is_amp(bus.X1_re) && is_amp(bus.X1_im) &&
                        is_amp(bus.X2_re) && is_amp(bus.X2_im);
               chk("sb_nibble", 32'(seen), 32'(exp_q[0]));
               chk("sb_mag", 32'(mag_ok), 1);
               chk("sb_last", 32'(bus.out_last), 32'((xfer_idx % FRAME) == FRAME - 1));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  xfer_idx++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(bus.in_byte[7:4]);
            exp_q.push_back(bus.in_byte[3:0]);
         end
      end
   end

   logic [7:0] sb[3] = '{8'h00, 8'hFF, 8'h3C};
   logic [7:0] fb[4];
   int         bi;
   int         idx;
   logic       acc;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_byte   = 8'h00;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk_zero("rst");
      cyc();
      rst_n = 1'b1;

      // Mapping of 0xA5 and one-cycle latency
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_byte   = 8'hA5;
      @(negedge clk);
      chk("a5_inready", 32'(bus.in_ready), 1);
      cyc();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("a5_lat", 32'(bus.out_valid), 0);
      cyc();
      @(negedge clk);
      chk("a5_hi_valid", 32'(bus.out_valid), 1);
      chk_sym("a5_hi", 4'hA);
      chk("a5_hi_last", 32'(bus.out_last), 0);
      cyc();
      @(negedge clk);
      chk("a5_lo_valid", 32'(bus.out_valid), 1);
      chk_sym("a5_lo", 4'h5);
      cyc();
      @(negedge clk);
      chk("a5_done", 32'(bus.out_valid), 0);

      // Back-to-back streaming of three bytes
      do_reset();
      bus.out_ready = 1'b1;
      bi            = 0;
      bus.in_valid  = 1'b1;
      bus.in_byte   = sb[0];
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c < 6) chk($sformatf("stream_inready%0d", c), 32'(bus.in_ready), (c % 2 == 0) ? 1 : 0);
         chk($sformatf("stream_valid%0d", c), 32'(bus.out_valid), (c >= 2 && c <= 7) ? 1 : 0);
         acc = bus.in_valid && bus.in_ready;
         cyc();
         if (acc) begin
            bi++;
            if (bi < 3) bus.in_byte = sb[bi];
            else bus.in_valid = 1'b0;
         end
      end

      // Backpressure on the first symbol of 0x1E
      do_reset();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_byte   = 8'h1E;
      @(negedge clk);
      chk("bp_accept", 32'(bus.in_ready), 1);
      cyc();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_lat", 32'(bus.out_valid), 0);
      cyc();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp_valid%0d", c), 32'(bus.out_valid), 1);
         chk_sym($sformatf("bp_hold%0d", c), 4'h1);
         chk($sformatf("bp_inready%0d", c), 32'(bus.in_ready), 0);
         cyc();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_valid", 32'(bus.out_valid), 1);
      chk_sym("bp_rel", 4'h1);
      cyc();
      @(negedge clk);
      chk("bp_lo_valid", 32'(bus.out_valid), 1);
      chk_sym("bp_lo", 4'hE);
      cyc();
      @(negedge clk);
      chk("bp_done", 32'(bus.out_valid), 0);

      // Frame marker over two frames of four symbols
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
      bi           = 0;
      idx          = 0;
      bus.in_valid = 1'b1;
      bus.in_byte  = fb[0];
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            idx++;
            chk($sformatf("frame_last%0d", idx), 32'(bus.out_last), 32'(idx == 4 || idx == 8));
         end
         acc = bus.in_valid && bus.in_ready;
         cyc();
         if (acc) begin
            bi++;
            if (bi < 4) bus.in_byte = fb[bi];
            else bus.in_valid = 1'b0;
         end
      end
      chk("frame_count", idx, 8);

      // Asynchronous reset while the low nibble is pending
      do_reset();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_byte   = 8'($urandom);
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("rm_pre_valid", 32'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("rm_async");
      cyc();
      cyc();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_byte   = 8'h80;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("rm_80_valid", 32'(bus.out_valid), 1);
      chk_sym("rm_80", 4'h8);
      chk("rm_80_last", 32'(bus.out_last), 0);
      repeat (3) cyc();

      // Random traffic checked by the scoreboard
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_byte   = 8'($urandom);
         cyc();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (6) cyc();
      @(negedge clk);
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_valid", 32'(bus.out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/qpsk_map_mimo.md
QPSK_MAP_MIMO -- requirements
Module: qpsk_map_mimo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the signed sample width of each symbol component.
REQ-002 The block SHALL have parameter AMP, default 23170, meaning the constellation magnitude; it SHALL be positive and at most 2^(DATA_W-1)-1.
REQ-003 The block SHALL have parameter FRAME_SYMS, default 64, meaning symbols per frame; it SHALL be at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_byte is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 The block SHALL have port in_byte, input, 8 bits: payload byte carrying two symbol vectors.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the symbol outputs are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumes the symbol this cycle.
REQ-011 The block SHALL have ports X1_re, X1_im, X2_re, X2_im, output, signed DATA_W bits each: the antenna 1 and antenna 2 I/Q samples.
REQ-012 The block SHALL have port out_last, output, 1 bit: the current symbol is the last of its frame.

Function
REQ-013 Handshakes: input transfer when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-014 Definition: slot_free = !out_valid || out_ready.
REQ-015 FSM states:
- IDLE: byte buffer empty.
- HI: high nibble pending.
- LO: low nibble pending.
REQ-016 in_ready SHALL be combinational: 1 in IDLE; slot_free in LO; 0 in HI.
REQ-017 IDLE: on input transfer, latch in_byte into the buffer and go to HI; otherwise stay.
REQ-018 HI: if slot_free, load the output register from buffer[7:4], set out_valid=1, go to LO; otherwise hold.
REQ-019 LO: if slot_free, load the output register from buffer[3:0] and set out_valid=1. Simultaneously, on input transfer, latch the new byte and go to HI; otherwise go to IDLE.
REQ-020 If no load occurs and an output transfer occurs, out_valid SHALL clear next edge.
REQ-021 While out_valid=1 && out_ready=0, all symbol outputs and out_last SHALL remain stable.
REQ-022 Nibble mapping: n[3] drives X1_re, n[2] drives X1_im, n[1] drives X2_re, n[0] drives X2_im. Bit 0 maps to +AMP; bit 1 maps to -AMP (two's complement). This is bit-exact inverse of the sign-slicing demapper.
REQ-023 Latency: a byte accepted at edge k SHALL present its high-nibble symbol with out_valid=1 after edge k+1. The low-nibble symbol SHALL follow at the first edge after k+1 at which out_ready=1.
REQ-024 Throughput: with out_ready held 1 and in_valid held 1, out_valid SHALL stay 1 continuously (one symbol per cycle, one byte per two cycles).
REQ-025 Frame counter: sym_cnt, range 0..FRAME_SYMS-1, SHALL increment on each output register load. It SHALL wrap to 0 after FRAME_SYMS-1.
REQ-026 out_last SHALL be registered with the symbol, equal to 1 when that symbol's sym_cnt value is FRAME_SYMS-1.
REQ-027 Backpressure SHALL never drop, duplicate or reorder nibbles.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state IDLE, buffer 0, sym_cnt 0, out_valid 0, out_last 0, X1_re/X1_im/X2_re/X2_im 0, in_ready 1.
REQ-029 Reset asserted mid-operation SHALL discard any buffered byte and the pending output symbol immediately (asynchronously).
REQ-030 After release, the first accepted byte SHALL start a new frame at sym_cnt 0.

Verification
REQ-031 Mapping: AMP=23170, out_ready=1; send 0xA5.
- Expected: (-23170, +23170, -23170, +23170) one cycle after acceptance.
- Then: (+23170, -23170, +23170, -23170) the next cycle.
REQ-032 Streaming: out_ready=1; send 0x00, 0xFF, 0x3C back-to-back.
- Expected: six consecutive valid symbols with no gap.
- in_ready pattern: 1,0,1,0,1,0.
REQ-033 Backpressure: send 0x1E; hold out_ready=0 for 5 cycles after the first symbol.
- Outputs SHALL stay (+,+,+,-) and in_ready SHALL stay 0.
- Release: (-,-,-,+) follows, then out_valid=0.
REQ-034 Frame: FRAME_SYMS=4; stream 4 bytes.
- out_last SHALL be 1 exactly on symbols 4 and 8.
- sym_cnt SHALL wrap to 0.
REQ-035 Reset: assert rst_n=0 while in LO with out_valid=1.
- Outputs SHALL go to 0 immediately.
- After release, next byte 0x80 SHALL give (-,+,+,+) with out_last=0.
REQ-036 Random: random in_valid/out_ready for 10k cycles. A scoreboard feeding outputs through a sign-slicing demapper SHALL recover the exact input byte stream.
